// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
//
// Two-read / one-write register file that supplies the operand pair to the
// downstream 2:1 operand-select mux. Both read ports are registered, so
// rdata0/rdata1 drive the mux a/b inputs directly with a full cycle of slack.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset; clears array and outputs,
//                and drops any read or write presented in the same cycle
//   wena    in   write enable
//   waddr   in   [ADDR_W-1:0] write address
//   wdata   in   [WIDTH-1:0]  write data
//   rena    in   read enable shared by both read ports
//   raddr0  in   [ADDR_W-1:0] read address, port 0
//   raddr1  in   [ADDR_W-1:0] read address, port 1
//   rdata0  out  [WIDTH-1:0]  registered read data, port 0 (mux a)
//   rdata1  out  [WIDTH-1:0]  registered read data, port 1 (mux b)
//   rvalid  out  one-cycle strobe marking fresh rdata0/rdata1
//
// Configuration macro: REGFILE_FORWARD_EN
//   defined   - a read colliding with a same-edge write returns wdata
//   undefined - a colliding read returns the pre-write entry contents

module reg_file_2r1w #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wena,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rena,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd0_next;
    logic [WIDTH-1:0] rd1_next;

    // Read-port source selection. The array read is the pre-write value
    // because the write lands on the same edge the read data is captured.
`ifdef REGFILE_FORWARD_EN
    always_comb begin
        rd0_next = mem[raddr0];
        rd1_next = mem[raddr1];
        if (wena && (waddr == raddr0)) rd0_next = wdata;
        if (wena && (waddr == raddr1)) rd1_next = wdata;
    end
`else
    always_comb begin
        rd0_next = mem[raddr0];
        rd1_next = mem[raddr1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata0 <= '0;
            rdata1 <= '0;
            rvalid <= 1'b0;
        end else begin
            if (wena) begin
                mem[waddr] <= wdata;
            end
            rvalid <= rena;
            if (rena) begin
                rdata0 <= rd0_next;
                rdata1 <= rd1_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w: directed vectors with literal expectations,
// plus a behavioural model compared against the DUT every cycle.

module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        wena;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        rena;
    logic [2:0]  raddr0;
    logic [2:0]  raddr1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        rvalid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_file_2r1w #(.WIDTH(32), .ADDR_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .wena   (wena),
        .waddr  (waddr),
        .wdata  (wdata),
        .rena   (rena),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .rvalid (rvalid)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Behavioural model: an array of words and the three output values.
    logic [31:0] m_mem [8];
    logic [31:0] m_r0 = 32'h0;
    logic [31:0] m_r1 = 32'h0;
    logic        m_rv = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
            m_r0 = 32'h0;
            m_r1 = 32'h0;
            m_rv = 1'b0;
        end else begin
            if (rena) begin
                m_r0 = (FWD && wena && waddr == raddr0) ? wdata : m_mem[raddr0];
                m_r1 = (FWD && wena && waddr == raddr1) ? wdata : m_mem[raddr1];
            end
            m_rv = rena;
            if (wena) m_mem[waddr] = wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_rdata0", rdata0, m_r0);
        check("model_rdata1", rdata1, m_r1);
        check("model_rvalid", {31'h0, rvalid}, {31'h0, m_rv});
    end

    // Present one cycle of inputs; returns at the following negedge so the
    // registered outputs reflect the edge that sampled these inputs.
    task automatic drive(input logic r, input logic we, input logic [2:0] wa,
                         input logic [31:0] wd, input logic re,
                         input logic [2:0] ra0, input logic [2:0] ra1);
        rst = r; wena = we; waddr = wa; wdata = wd;
        rena = re; raddr0 = ra0; raddr1 = ra1;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        rst = 1'b1; wena = 1'b0; waddr = '0; wdata = '0;
        rena = 1'b0; raddr0 = '0; raddr1 = '0;
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0);
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);

        // Reset clears a previously written entry
        drive(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 3'd0);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 3'd5);
        check("rst_clear_r0", rdata0, 32'h0);
        check("rst_clear_r1", rdata1, 32'h0);
        check("rst_clear_rv", {31'h0, rvalid}, 32'h1);
        idle();
        check("rvalid_drop", {31'h0, rvalid}, 32'h0);

        // Write then read on both ports
        drive(1'b0, 1'b1, 3'd2, 32'h11111111, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 1'b1, 3'd6, 32'h22222222, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 3'd6);
        check("wr_rd_r0", rdata0, 32'h11111111);
        check("wr_rd_r1", rdata1, 32'h22222222);
        check("wr_rd_rv", {31'h0, rvalid}, 32'h1);
        idle();
        check("wr_rd_rv_single", {31'h0, rvalid}, 32'h0);

        // Collision on port 0; port 1 reads a different entry
        drive(1'b0, 1'b1, 3'd3, 32'hAAAAAAAA, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 1'b1, 3'd3, 32'h55555555, 1'b1, 3'd3, 3'd2);
        check("collide_r0", rdata0, FWD ? 32'h55555555 : 32'hAAAAAAAA);
        check("collide_r1_other", rdata1, 32'h11111111);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd3);
        check("after_collide_r0", rdata0, 32'h55555555);
        check("after_collide_r1", rdata1, 32'h55555555);

        // Hold while rena is low, with writes to the read entry
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 3'd6);
        check("hold_pre_r0", rdata0, 32'h11111111);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 3'd2, 3'd2);
            check("hold_r0", rdata0, 32'h11111111);
            check("hold_rv", {31'h0, rvalid}, 32'h0);
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 3'd2);
        check("hold_after_r0", rdata0, 32'hFFFFFFFF);

        // Streaming reads after filling entry i with i*0x01010101
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 3'(i), 32'h01010101 * i, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'(i), 3'(7 - i));
            check("stream_r0", rdata0, 32'h01010101 * i);
            check("stream_r1", rdata1, 32'h01010101 * (7 - i));
            check("stream_rv", {31'h0, rvalid}, 32'h1);
        end

        // Reset overrides a write and a read presented in the same cycle
        drive(1'b1, 1'b1, 3'd1, 32'h12345678, 1'b1, 3'd1, 3'd1);
        check("rst_mid_r0", rdata0, 32'h0);
        check("rst_mid_rv", {31'h0, rvalid}, 32'h0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 3'd7);
        check("rst_mid_read1", rdata0, 32'h0);
        check("rst_mid_read7", rdata1, 32'h0);
        idle();
        idle();

        #2;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Two-read/one-write register file that supplies the 32-bit operand pair to the downstream 2:1 operand-select mux. Both read ports are registered, so their outputs drive the mux `a` and `b` inputs directly. One synchronous write port receives write-back data. An optional write-to-read bypass lets a value written in a cycle be read back in that same cycle.

## Interface
- `WIDTH`, 32, data width of each entry and of each port
- `ADDR_W`, 3, address width; depth is fixed at 2**ADDR_W entries (8 by default)

- `clk`  input  1  single clock; all state changes on its rising edge
- `rst`  input  1  synchronous, active-high reset
- `wena`  input  1  write enable
- `waddr`  input  ADDR_W  write address
- `wdata`  input  WIDTH  write data
- `rena`  input  1  read enable, shared by both read ports
- `raddr0`  input  ADDR_W  read address, port 0
- `raddr1`  input  ADDR_W  read address, port 1
- `rdata0`  output  WIDTH  registered read data, port 0; drives mux `a`
- `rdata1`  output  WIDTH  registered read data, port 1; drives mux `b`
- `rvalid`  output  1  high for one cycle when `rdata0`/`rdata1` carry fresh data

## Operation
- **Storage:** 2**ADDR_W entries of WIDTH bits. There is no hardwired-zero entry; every address is writable.
- **Reset:** while `rst`=1 at a clock edge:
  - all entries clear to 0
  - `rdata0`/`rdata1` clear to 0
  - `rvalid` clears to 0
  - `rst` overrides `wena` and `rena`; a write or read presented in a reset cycle is dropped
- **Write:** `wena`=1 at an edge stores `wdata` into entry `waddr`. `wena`=0 leaves the array unchanged.
- **Read:** `rena`=1 at an edge loads `rdata0` <= entry[`raddr0`] and `rdata1` <= entry[`raddr1`].
  - `rvalid` <= `rena` on every non-reset edge.
  - While `rena`=0, `rdata0`/`rdata1` hold their last value and `rvalid`=0.
- **Same address on both read ports:** legal; both outputs return the same value.
- **Simultaneous read and write to the same address (collision):** resolved by the `REGFILE_FORWARD_EN` macro; see Configuration.
- **Non-colliding reads:** unaffected by a concurrent write to a different address.
- **Address range:** every ADDR_W-bit address is valid, so no range check is needed.

## Timing
- Read latency is 1 cycle: addresses sampled at edge N produce data and `rvalid` after edge N.
- A write at edge N becomes visible to a read sampled at edge N+1 or later, in every configuration.
- Back-to-back reads with `rena` held high give one new result per cycle, with `rvalid` continuously 1.
- Outputs are registered, with no combinational path from inputs to outputs, so they feed the combinational mux with a full cycle of slack.
- Reset asserted mid-stream: the next edge forces all outputs to 0 and discards any in-flight write.

## Configuration
- **Macro:** `REGFILE_FORWARD_EN`.
- **Defined:** on a collision at an edge (`rena`=1, `wena`=1, `raddrX`==`waddr`), port X captures `wdata`, the new value. Each port forwards independently.
- **Undefined:** on the same collision, port X captures the pre-write entry contents, the old value. The new value appears on the next read.
- Writes and non-colliding reads behave identically in both configurations.

## Test plan
- **Reset:** write 0xDEADBEEF to entry 5, then pulse `rst`, then read addresses 5 and 5 -> `rdata0`=`rdata1`=0, and `rvalid`=1 one cycle after `rena`.
- **Write-then-read:** write 0x11111111 to entry 2 and 0x22222222 to entry 6. Next cycle, read `raddr0`=2, `raddr1`=6 -> after one cycle `rdata0`=0x11111111, `rdata1`=0x22222222, `rvalid`=1 for that single cycle.
- **Collision:** entry 3 holds 0xAAAAAAAA. In the same cycle, write 0x55555555 to entry 3 and read `raddr0`=3 -> `rdata0`=0x55555555 with `REGFILE_FORWARD_EN`, 0xAAAAAAAA without. A read of entry 3 on the following cycle returns 0x55555555 in both configurations.
- **Hold:** after reading 0x11111111, drop `rena` for 4 cycles while writing 0xFFFFFFFF to entry 2 -> `rdata0` stays 0x11111111 and `rvalid`=0 throughout.
- **Streaming:** hold `rena`=1 with `raddr0` stepping 0..7 after filling entry i with i*0x01010101 -> `rdata0` returns 0x00000000, 0x01010101, … 0x07070707 on consecutive cycles, with `rvalid` continuously 1.
- **Reset mid-write:** assert `rst` in the same cycle as a write of 0x12345678 to entry 1 -> a later read of entry 1 returns 0.
